// File: rtl/abs_diff_approx_pipe.sv
// abs_diff_approx_pipe: two-stage |a-b| unit with a per-transaction approximate mode
//   (low ZERO_LSBS result bits forced to 0) and an on-line error/statistics monitor.
// Latency: 2 cycles (operands accepted at edge N appear on out_* after edge N+1).
// Backpressure: S2 holds while out_ready is low; S1 keeps filling; in_ready drops only
//   when both stages are full. in_ready is combinational from out_ready and stage state.
// Ports: clk/rst_n; in_valid/in_ready/in_a/in_b/approx_en operand stream;
//   out_valid/out_ready/out_diff/out_err result stream; sample_cnt/err_cnt/max_err/et_viol
//   statistics, cleared synchronously by clr_stats.
module abs_diff_approx_pipe #(
  parameter int unsigned OP_W      = 8,
  parameter int unsigned ZERO_LSBS = 2,
  parameter int unsigned ET        = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OP_W-1:0]      in_a,
  input  logic [OP_W-1:0]      in_b,
  input  logic                 approx_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OP_W-1:0]      out_diff,
  output logic [ZERO_LSBS-1:0] out_err,
  output logic [CNT_W-1:0]     sample_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [ZERO_LSBS-1:0] max_err,
  output logic                 et_viol,
  input  logic                 clr_stats
);

  localparam logic [31:0] ET_L = 32'(ET);

  logic                 s1_v_q, s1_v_d;
  logic                 s2_v_q, s2_v_d;
  logic [OP_W-1:0]      a_q, a_d;
  logic [OP_W-1:0]      b_q, b_d;
  logic                 ap_q, ap_d;
  logic [OP_W-1:0]      diff_q, diff_d;
  logic [ZERO_LSBS-1:0] err_q, err_d;
  logic [CNT_W-1:0]     sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;
  logic [ZERO_LSBS-1:0] max_err_q, max_err_d;
  logic                 et_viol_q, et_viol_d;

  logic                 adv2;
  logic                 in_fire;
  logic                 out_fire;
  logic [OP_W-1:0]      exact;

  // S2 can take new data when empty or draining this cycle; S1 advances in lockstep.
  assign adv2     = ~s2_v_q | out_ready;
  // Gating with rst_n keeps in_ready low during reset even though both stages read empty.
  assign in_ready = rst_n & (~s1_v_q | adv2);
  assign in_fire  = in_valid & in_ready;
  assign out_fire = s2_v_q & out_ready;

  assign exact = (a_q >= b_q) ? (a_q - b_q) : (b_q - a_q);

  always_comb begin
    s1_v_d       = s1_v_q;
    s2_v_d       = s2_v_q;
    a_d          = a_q;
    b_d          = b_q;
    ap_d         = ap_q;
    diff_d       = diff_q;
    err_d        = err_q;
    sample_cnt_d = sample_cnt_q;
    err_cnt_d    = err_cnt_q;
    max_err_d    = max_err_q;
    et_viol_d    = et_viol_q;

    // S1: refill on accept, otherwise empty out when S2 takes the entry.
    s1_v_d = in_fire | (s1_v_q & ~adv2);
    if (in_fire) begin
      a_d  = in_a;
      b_d  = in_b;
      ap_d = approx_en;
    end

    // S2: only overwrite result registers when a real entry moves in, so a bubble
    // leaves the last result untouched.
    if (adv2) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        if (ap_q) begin
          diff_d = {exact[OP_W-1:ZERO_LSBS], {ZERO_LSBS{1'b0}}};
          err_d  = exact[ZERO_LSBS-1:0];
        end else begin
          diff_d = exact;
          err_d  = '0;
        end
      end
    end

    // Statistics: clear has priority over the sample handshaken in the same cycle.
    if (clr_stats) begin
      sample_cnt_d = '0;
      err_cnt_d    = '0;
      max_err_d    = '0;
      et_viol_d    = 1'b0;
    end else if (out_fire) begin
      if (sample_cnt_q != '1) sample_cnt_d = sample_cnt_q + CNT_W'(1);
      if ((err_q != '0) && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
      if (err_q > max_err_q) max_err_d = err_q;
      if (32'(err_q) > ET_L) et_viol_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q       <= 1'b0;
      s2_v_q       <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      ap_q         <= 1'b0;
      diff_q       <= '0;
      err_q        <= '0;
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      max_err_q    <= '0;
      et_viol_q    <= 1'b0;
    end else begin
      s1_v_q       <= s1_v_d;
      s2_v_q       <= s2_v_d;
      a_q          <= a_d;
      b_q          <= b_d;
      ap_q         <= ap_d;
      diff_q       <= diff_d;
      err_q        <= err_d;
      sample_cnt_q <= sample_cnt_d;
      err_cnt_q    <= err_cnt_d;
      max_err_q    <= max_err_d;
      et_viol_q    <= et_viol_d;
    end
  end

  assign out_valid  = s2_v_q;
  assign out_diff   = diff_q;
  assign out_err    = err_q;
  assign sample_cnt = sample_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign max_err    = max_err_q;
  assign et_viol    = et_viol_q;

endmodule

// File: tb/tb_abs_diff_approx_pipe.sv
// Scoreboard bench for abs_diff_approx_pipe: directed cases plus randomized traffic
// with random output backpressure; a negedge monitor checks results and statistics.
module tb_abs_diff_approx_pipe;

  localparam int OP_W = 8;
  localparam int ZL   = 2;
  localparam int ET   = 1;
  localparam int CW   = 16;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          in_valid = 1;
  logic          in_ready;
  logic [OP_W-1:0] in_a = 0, in_b = 0;
  logic          approx_en = 0;
  logic          out_valid;
  logic          out_ready;
  logic [OP_W-1:0] out_diff;
  logic [ZL-1:0] out_err;
  logic [CW-1:0] sample_cnt, err_cnt;
  logic [ZL-1:0] max_err;
  logic          et_viol;
  logic          clr_stats = 0;

  // 0: always ready, 1: always stalled, 2: random
  int   bp_mode = 0;
  logic rnd_rdy = 1;
  assign out_ready = (bp_mode == 0) ? 1'b1 : (bp_mode == 1) ? 1'b0 : rnd_rdy;

  always #5 clk = ~clk;

  abs_diff_approx_pipe #(.OP_W(OP_W), .ZERO_LSBS(ZL), .ET(ET), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .approx_en(approx_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_diff(out_diff), .out_err(out_err),
    .sample_cnt(sample_cnt), .err_cnt(err_cnt), .max_err(max_err), .et_viol(et_viol),
    .clr_stats(clr_stats)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct { int d; int e; } exp_t;
  exp_t exp_q[$];

  // Reference: plain integer |a-b|; approximate mode drops the remainder modulo 2^ZL.
  function automatic exp_t ref_model(input int a, input int b, input bit ap);
    exp_t r;
    int diff;
    diff = (a > b) ? a - b : b - a;
    r.e  = ap ? diff % (1 << ZL) : 0;
    r.d  = diff - r.e;
    return r;
  endfunction

  // Model statistics
  int m_cnt = 0, m_ecnt = 0, m_max = 0;
  bit m_viol = 0;
  bit hold_v = 0;
  int hold_d = 0, hold_e = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sample_cnt", sample_cnt, 0);
      chk("rst_err_cnt", err_cnt, 0);
      chk("rst_max_err", max_err, 0);
      chk("rst_et_viol", et_viol, 0);
      exp_q.delete();
      m_cnt = 0; m_ecnt = 0; m_max = 0; m_viol = 0; hold_v = 0;
    end else begin
      chk("sample_cnt", sample_cnt, m_cnt);
      chk("err_cnt", err_cnt, m_ecnt);
      chk("max_err", max_err, m_max);
      chk("et_viol", et_viol, m_viol);
      if (hold_v && out_valid) begin
        chk("stall_diff_stable", out_diff, hold_d);
        chk("stall_err_stable", out_err, hold_e);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_output: got diff %0d with empty scoreboard", out_diff);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_diff", out_diff, e.d);
          chk("out_err", out_err, e.e);
          if (!clr_stats) begin
            if (m_cnt < (1 << CW) - 1) m_cnt++;
            if (e.e != 0 && m_ecnt < (1 << CW) - 1) m_ecnt++;
            if (e.e > m_max) m_max = e.e;
            if (e.e > ET) m_viol = 1;
          end
        end
      end
      if (clr_stats) begin
        m_cnt = 0; m_ecnt = 0; m_max = 0; m_viol = 0;
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_diff;
      hold_e = out_err;
      if (in_valid && in_ready) exp_q.push_back(ref_model(in_a, in_b, approx_en));
    end
  end

  always @(posedge clk) begin
    #1;
    rnd_rdy = ($urandom_range(0, 3) != 0);
  end

  // Inputs change at posedge+1; in_ready is read at posedge+2, after out_ready settles.
  task automatic send(input int a, input int b, input bit ap);
    int n = 0;
    in_a = OP_W'(a); in_b = OP_W'(b); approx_en = ap; in_valid = 1;
    #1;
    while (!in_ready && n < 500) begin
      @(posedge clk); #2; n++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int k;
    int n;
    // Reset held with in_valid high; monitor checks outputs every negedge.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready_direct", in_ready, 0);
    in_valid = 0;
    rst_n = 1;
    #1;
    chk("in_ready_after_release", in_ready, 1);
    @(posedge clk); #1;

    // Exact transaction with latency check
    bp_mode = 0;
    send(200, 55, 0);
    chk("latency_not_early", out_valid, 0);
    @(posedge clk); #1;
    chk("latency_valid", out_valid, 1);
    chk("exact_diff", out_diff, 145);
    chk("exact_err", out_err, 0);
    send(55, 200, 1);
    send(10, 3, 1);
    drain();
    chk("dir_sample_cnt", sample_cnt, 3);
    chk("dir_err_cnt", err_cnt, 2);
    chk("dir_max_err", max_err, 3);
    chk("dir_et_viol", et_viol, 1);
    send(5, 5, 0);
    send(9, 9, 1);
    drain();
    chk("viol_sticky", et_viol, 1);
    chk("equal_diff", out_diff, 0);

    // Backpressure: 5 stalled cycles accept exactly 2 of k=1..6
    bp_mode = 1;
    acc = 0;
    k = 1;
    in_valid = 1;
    for (int c = 0; c < 5; c++) begin
      in_a = OP_W'(k); in_b = 0; approx_en = 0;
      #1;
      if (in_ready) begin acc++; k++; end
      @(posedge clk); #1;
    end
    in_valid = 0;
    chk("bp_accepted", acc, 2);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_head_diff", out_diff, 1);
    bp_mode = 0;
    while (k <= 6) begin
      send(k, 0, 0);
      k++;
    end
    drain();

    // clr_stats coinciding with a handshake
    send(100, 1, 1);
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("clr_out_valid", out_valid, 1);
    clr_stats = 1;
    @(posedge clk); #1;
    clr_stats = 0;
    chk("clr_sample_cnt", sample_cnt, 0);
    chk("clr_err_cnt", err_cnt, 0);
    chk("clr_max_err", max_err, 0);
    chk("clr_et_viol", et_viol, 0);

    // Randomized traffic with random backpressure
    bp_mode = 2;
    for (int i = 0; i < 300; i++) begin
      send($urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 7) == 0) begin @(posedge clk); #1; end
    end
    bp_mode = 0;
    drain();

    // Reset with both stages full
    bp_mode = 1;
    send(7, 1, 0);
    send(8, 2, 0);
    chk("full_out_valid", out_valid, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1;
    bp_mode = 0;
    #1;
    chk("mid_rst_release_ready", in_ready, 1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("no_stale_out", out_valid, 0);
    end
    send(3, 250, 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
